median_filter_ctrl: RTL and testbench

Sequencer that sits in front of the `median_filter` datapath. It gathers a raster-ordered pixel stream into one R_I×C_I tile buffer and drives the filter's `cen` for exactly the filter's pipeline latency. It then captures the filtered tile and streams it back out in raster order. It is the only block that asserts the filter's clock enable, so the filter never advances on partial or stale data.

---
 rtl/median_ctrl_pkg.sv | 32 +++
 rtl/median_tile_buf.sv | 51 +++++
 rtl/median_filter_ctrl.sv | 165 ++++++++++++++++
 tb/tb_median_filter_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/median_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// median_ctrl_pkg
// Shared types and helpers for the median filter sequencer.
//   ctrl_state_t : sequencer states LOAD -> RUN -> CAPTURE -> DRAIN
//   pix_t        : one unsigned pixel at the default pixel width
//   tile_t       : one [rows][cols] tile of pix_t at the default geometry
//   idx_width()  : bit width of a counter that spans 0..n-1 (at least 1 bit)
// Optional feature macro used by the top: MEDIAN_CTRL_BYPASS_EN.
// -----------------------------------------------------------------------------
package median_ctrl_pkg;

    localparam int R_DEF   = 16;
    localparam int C_DEF   = 16;
    localparam int W_DEF   = 8;
    localparam int LAT_DEF = 22;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } ctrl_state_t;

    typedef logic [W_DEF-1:0] pix_t;
    typedef pix_t [R_DEF-1:0][C_DEF-1:0] tile_t;

    // A one-entry range still needs a one-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_tile_buf.sv
// -----------------------------------------------------------------------------
// median_tile_buf
// N-entry pixel register array holding one tile.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset (clears to zero)
//   wr_en/wr_idx/wr_data single-pixel write port
//   load_en/load_tile    full-tile parallel load (wins over a pixel write)
//   rd_idx/rd_data       single-pixel combinational read port
//   tile                 full-tile parallel read, pixel i at bits [i*W +: W]
// -----------------------------------------------------------------------------
module median_tile_buf
    import median_ctrl_pkg::*;
#(
    parameter int N  = 256,
    parameter int W  = 8,
    parameter int IW = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [W-1:0]    wr_data,
    input  logic            load_en,
    input  logic [N*W-1:0]  load_tile,
    input  logic [IW-1:0]   rd_idx,
    output logic [W-1:0]    rd_data,
    output logic [N*W-1:0]  tile
);

    logic [W-1:0] mem_reg [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    mem_reg[gi] <= '0;
                end else if (load_en) begin
                    mem_reg[gi] <= load_tile[gi*W +: W];
                end else if (wr_en && (wr_idx == IW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end

            assign tile[gi*W +: W] = mem_reg[gi];
        end
    endgenerate

    assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/median_filter_ctrl.sv
// -----------------------------------------------------------------------------
// median_filter_ctrl
// Sequencer in front of the median_filter datapath. Collects one raster-order
// tile, enables the filter for exactly LAT edges, captures the filtered tile
// and streams it back out in raster order. Input and output tiles never
// overlap; the filter only advances while a complete tile is presented.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data    input pixel stream (ready only in LOAD)
//   flt_cen                   filter clock enable (high only in RUN)
//   flt_img                   tile to the filter, pixel i at bits [i*W_I +: W_I]
//   flt_res                   filtered tile from the filter, same layout
//   m_valid/m_ready/m_data    output pixel stream (valid only in DRAIN)
//   m_last                    marks output pixel N-1
//   busy                      high whenever not in LOAD
//   bypass                    only with MEDIAN_CTRL_BYPASS_EN: sampled on the
//                             edge accepting the last pixel; 1 skips filtering
// -----------------------------------------------------------------------------
module median_filter_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int R_I = R_DEF,
    parameter int C_I = C_DEF,
    parameter int W_I = W_DEF,
    parameter int LAT = LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W_I-1:0]         s_data,
    output logic                   flt_cen,
    output logic [R_I*C_I*W_I-1:0] flt_img,
    input  logic [R_I*C_I*W_I-1:0] flt_res,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [W_I-1:0]         m_data,
    output logic                   m_last,
    output logic                   busy
`ifdef MEDIAN_CTRL_BYPASS_EN
    ,
    input  logic                   bypass
`endif
);

    localparam int N  = R_I * C_I;
    localparam int IW = idx_width(N);
    localparam int RW = idx_width(LAT);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(LAT - 1);

    ctrl_state_t   state_reg, state_next;
    logic [IW-1:0] px_cnt_reg, px_cnt_next;
    logic [IW-1:0] out_cnt_reg, out_cnt_next;
    logic [RW-1:0] run_cnt_reg, run_cnt_next;

    logic          buf_wr;
    logic          buf_load;
    logic [W_I-1:0] rd_pix;

    median_tile_buf #(
        .N  (N),
        .W  (W_I),
        .IW (IW)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (buf_wr),
        .wr_idx    (px_cnt_reg),
        .wr_data   (s_data),
        .load_en   (buf_load),
        .load_tile (flt_res),
        .rd_idx    (out_cnt_reg),
        .rd_data   (rd_pix),
        .tile      (flt_img)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= LOAD;
            px_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            run_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            px_cnt_reg  <= px_cnt_next;
            out_cnt_reg <= out_cnt_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    // Handshake outputs depend on state only; s_valid/m_ready only steer the
    // counters and the next state, so there is no combinational ready/valid path.
    always_comb begin
        state_next   = state_reg;
        px_cnt_next  = px_cnt_reg;
        out_cnt_next = out_cnt_reg;
        run_cnt_next = run_cnt_reg;
        s_ready      = 1'b0;
        flt_cen      = 1'b0;
        m_valid      = 1'b0;
        m_data       = '0;
        m_last       = 1'b0;
        buf_wr       = 1'b0;
        buf_load     = 1'b0;

        case (state_reg)
            LOAD: begin
                s_ready = 1'b1;
                buf_wr  = s_valid;
                if (s_valid) begin
                    if (px_cnt_reg == LAST_IDX) begin
                        px_cnt_next  = '0;
                        run_cnt_next = '0;
`ifdef MEDIAN_CTRL_BYPASS_EN
                        // Bypassed tiles stream straight out of the buffer.
                        state_next   = bypass ? DRAIN : RUN;
`else
                        state_next   = RUN;
`endif
                    end else begin
                        px_cnt_next = px_cnt_reg + 1'b1;
                    end
                end
            end

            RUN: begin
                // Buffer is not written here, so flt_img is stable for all LAT edges.
                flt_cen      = 1'b1;
                run_cnt_next = run_cnt_reg + 1'b1;
                if (run_cnt_reg == RUN_LAST) begin
                    state_next = CAPTURE;
                end
            end

            CAPTURE: begin
                buf_load   = 1'b1;
                state_next = DRAIN;
            end

            DRAIN: begin
                // out_cnt only moves on acceptance, so m_data/m_last hold while stalled.
                m_valid = 1'b1;
                m_data  = rd_pix;
                m_last  = (out_cnt_reg == LAST_IDX);
                if (m_ready) begin
                    if (out_cnt_reg == LAST_IDX) begin
                        out_cnt_next = '0;
                        state_next   = LOAD;
                    end else begin
                        out_cnt_next = out_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign busy = (state_reg != LOAD);

endmodule

// File: tb/tb_median_filter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_median_filter_ctrl
// Self-checking bench for median_filter_ctrl (R_I=C_I=16, W_I=8, LAT=22).
// The filter is stood in for by a model that adds 1 to every pixel. Each tile
// is checked against a reference list of pixels, with cycle timing measured
// from the edge accepting the last input pixel. Define MEDIAN_CTRL_BYPASS_EN
// to also exercise bypassed tiles.
// -----------------------------------------------------------------------------
module tb_median_filter_ctrl;

    localparam int R   = 16;
    localparam int C   = 16;
    localparam int W   = 8;
    localparam int LAT = 22;
    localparam int N   = R * C;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           flt_cen;
    logic [N*W-1:0] flt_img;
    logic [N*W-1:0] flt_res;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           busy;
    logic           bypass = 1'b0;

    int cyc = 0;
    int vec_cnt = 0;
    int err_cnt = 0;
    int last_out_cyc = 0;
    int tile_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in filter: every pixel incremented by one (mod 256).
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_flt
            assign flt_res[gi*W +: W] = flt_img[gi*W +: W] + 8'd1;
        end
    endgenerate

    median_filter_ctrl #(
        .R_I (R),
        .C_I (C),
        .W_I (W),
        .LAT (LAT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .flt_cen (flt_cen),
        .flt_img (flt_img),
        .flt_res (flt_res),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
`ifdef MEDIAN_CTRL_BYPASS_EN
        ,
        .bypass  (bypass)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Runs one tile. Starts and ends at a falling edge.
    //   kind 0: ramp 0..N-1, 1: random, 2: all 0xAA
    //   rnd_v/rnd_r: random gaps on s_valid / random m_ready stalls
    //   byp: bypass requested at the last input pixel
    //   b2b: first accept must come the cycle after the previous tile's m_last
    //   abort_run >= 0: assert reset while run_cnt equals this value
    task automatic run_tile(input int kind, input bit rnd_v, input bit rnd_r,
                            input bit byp, input bit b2b, input int abort_run);
        logic [W-1:0] pix [N];
        logic [W-1:0] exp_pix;
        int idx, guard, cyc_t0, cen_n, oidx;
        bit acc;

        tile_no++;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       pix[i] = W'(i);
                1:       pix[i] = W'($urandom);
                default: pix[i] = 8'hAA;
            endcase
        end

        idx = 0;
        guard = 0;
        while (idx < N && guard < 8 * N) begin
            s_valid = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = s_valid ? pix[idx] : W'($urandom);
            bypass  = byp;
            acc = s_valid && s_ready;
            if (acc && idx == 0 && b2b)
                check_val("b2b_first_accept_gap", cyc - last_out_cyc, 1);
            if (acc) idx++;
            @(negedge clk);
            guard++;
        end
        if (idx < N) begin
            check_val("load_timeout", idx, N);
            s_valid = 1'b0;
            return;
        end

        // Now just after edge t0. Keep s_valid high with junk: it must be ignored.
        cyc_t0 = cyc;
        bypass = 1'b0;
        s_data = W'($urandom);
        check_val("s_ready_after_last", s_ready, 0);
        check_val("busy_after_last", busy, 1);

        if (abort_run >= 0) begin
            repeat (abort_run) @(negedge clk);
            check_val("cen_before_abort", flt_cen, 1);
            rstn = 1'b0;
            #1;
            check_val("abort_flt_cen", flt_cen, 0);
            check_val("abort_m_valid", m_valid, 0);
            check_val("abort_s_ready", s_ready, 1);
            check_val("abort_busy", busy, 0);
            s_valid = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            check_val("abort_released_idle", {busy, m_valid, s_ready}, 3'b001);
            $display("tile %0d: kind=%0d aborted by reset at run_cnt=%0d", tile_no, kind, abort_run);
            return;
        end

        cen_n = 0;
        guard = 0;
        while (!m_valid && guard < 4 * LAT) begin
            if (flt_cen) cen_n++;
            if (m_data != 0 || m_last != 0) check_val("idle_m_data_m_last", {m_last, m_data}, 0);
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        check_val("flt_cen_edges", cen_n, byp ? 0 : LAT);
        check_val("first_out_latency", cyc - cyc_t0, byp ? 0 : LAT + 1);

        oidx = 0;
        guard = 0;
        while (oidx < N && guard < 8 * N) begin
            exp_pix = byp ? pix[oidx] : pix[oidx] + 8'd1;
            check_val("m_valid_in_drain", m_valid, 1);
            check_val("m_data", m_data, exp_pix);
            check_val("m_last", m_last, (oidx == N - 1) ? 1 : 0);
            check_val("drain_cen_ready", {flt_cen, s_ready}, 2'b00);
            m_ready = rnd_r ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (m_ready) begin
                if (oidx == N - 1) last_out_cyc = cyc;
                oidx++;
            end
            @(negedge clk);
            guard++;
        end
        m_ready = 1'b0;
        if (oidx < N) begin
            check_val("drain_timeout", oidx, N);
            return;
        end
        check_val("post_tile_s_ready", s_ready, 1);
        check_val("post_tile_m_valid", m_valid, 0);
        check_val("post_tile_m_data", m_data, 0);
        check_val("post_tile_busy", busy, 0);
        $display("tile %0d: kind=%0d bypass=%0d %0d pixels in, %0d out, t0 cycle %0d",
                 tile_no, kind, byp, N, oidx, cyc_t0);
    endtask

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        bypass  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_s_ready", s_ready, 1);
        check_val("rst_flt_cen", flt_cen, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_data", m_data, 0);
        check_val("rst_m_last", m_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_flt_img", (flt_img == '0) ? 1 : 0, 1);
        rstn = 1'b1;
        @(negedge clk);

        run_tile(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // ramp, no stalls
        run_tile(1, 1'b1, 1'b1, 1'b0, 1'b0, -1);  // random gaps and stalls
        run_tile(1, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // back-to-back
        run_tile(1, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // back-to-back again
        run_tile(1, 1'b0, 1'b0, 1'b0, 1'b0, 10);  // reset mid-RUN
        run_tile(2, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // 0xAA after abort
        run_tile(1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
`ifdef MEDIAN_CTRL_BYPASS_EN
        run_tile(1, 1'b1, 1'b1, 1'b1, 1'b0, -1);  // bypassed
        run_tile(1, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // filtered again
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", err_cnt);
        $fatal(1, "watchdog");
    end

endmodule
